circle_scene: RTL and testbench

CIRCLE_SCENE -- requirements
Module: circle_scene

---
 rtl/circle_scene_pkg.sv | 34 +++
 rtl/circle_engine.sv | 117 +++++++++++
 rtl/circle_scene.sv | 151 +++++++++++++++
 tb/tb_circle_scene.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_scene_pkg.sv
// Shared types and helpers for the concentric-circle scene generator.
package circle_scene_pkg;

    localparam int COLOUR_W = 3;
    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW,
        S_WAIT,
        S_FINISH
    } scene_state_t;

    typedef enum logic {
        E_IDLE,
        E_RUN
    } engine_state_t;

    // Radius of circle k; anything past the 8-bit radius range sticks at 255.
    function automatic logic [7:0] circle_radius(input logic [7:0] base,
                                                 input logic [2:0] k,
                                                 input int         step);
        int sum;
        sum = int'(base) + int'(k) * step;
        return (sum > 255) ? 8'd255 : sum[7:0];
    endfunction

    // Colour of circle k cycles through 1..7 so black is never used for a circle.
    function automatic logic [COLOUR_W-1:0] circle_colour(input logic [2:0] k);
        return (k == 3'd7) ? 3'd1 : k + 3'd1;
    endfunction

endpackage

// File: rtl/circle_engine.sv
// Midpoint (Bresenham) circle plotter: one octant point per cycle, clipped
// to the screen. A start pulse in idle latches centre, radius and colour;
// done is high during the cycle of the final point.
module circle_engine
    import circle_scene_pkg::*;
#(
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          centre_x,
    input  logic [6:0]          centre_y,
    input  logic [7:0]          radius,
    input  logic [COLOUR_W-1:0] colour,
    output logic                done,
    output logic                pix_valid,
    output logic [7:0]          pix_x,
    output logic [6:0]          pix_y,
    output logic [COLOUR_W-1:0] pix_colour
);

    // Wide enough for centre +/- radius (-255..510) and the decision variable.
    typedef logic signed [11:0] coord_t;

    localparam coord_t W_LIM = coord_t'(SCR_W);
    localparam coord_t H_LIM = coord_t'(SCR_H);

    engine_state_t       state;
    coord_t              cx, cy;
    coord_t              ox, oy;
    coord_t              d;
    logic [2:0]          oct;
    logic [COLOUR_W-1:0] col;

    coord_t nx, ny, nd;
    coord_t px, py;
    logic   last_step;

    // Next midpoint step, taken once all eight points of the current one are out
    always_comb begin
        ny = oy + 12'sd1;
        if (d[11]) begin
            nx = ox;
            nd = d + (ny <<< 1) + 12'sd1;
        end else begin
            nx = ox - 12'sd1;
            nd = d + ((ny - nx) <<< 1) + 12'sd1;
        end
    end

    // Select the symmetric point for the current octant
    always_comb begin
        // NOTE: every path assigns px/py (default arm included), so no latch is inferred.
        case (oct)
            3'd0:    begin px = cx + ox; py = cy + oy; end
            3'd1:    begin px = cx + oy; py = cy + ox; end
            3'd2:    begin px = cx - oy; py = cy + ox; end
            3'd3:    begin px = cx - ox; py = cy + oy; end
            3'd4:    begin px = cx - ox; py = cy - oy; end
            3'd5:    begin px = cx - oy; py = cy - ox; end
            3'd6:    begin px = cx + oy; py = cy - ox; end
            default: begin px = cx + ox; py = cy - oy; end
        endcase
    end

    assign last_step  = (oct == 3'd7) && (ny > nx);
    assign done       = (state == E_RUN) && last_step;
    assign pix_valid  = (state == E_RUN) && !px[11] && (px < W_LIM) && !py[11] && (py < H_LIM);
    assign pix_x      = px[7:0];
    assign pix_y      = py[6:0];
    assign pix_colour = col;

    // Walk the octant points of each midpoint step, one point per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= E_IDLE;
            cx    <= '0;
            cy    <= '0;
            ox    <= '0;
            oy    <= '0;
            d     <= '0;
            oct   <= '0;
            col   <= COLOUR_BLACK;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                E_IDLE: begin
                    if (start) begin
                        cx    <= $signed({4'b0, centre_x});
                        cy    <= $signed({5'b0, centre_y});
                        ox    <= $signed({4'b0, radius});
                        oy    <= '0;
                        d     <= 12'sd1 - $signed({4'b0, radius});
                        oct   <= '0;
                        col   <= colour;
                        state <= E_RUN;
                    end
                end
                E_RUN: begin
                    oct <= oct + 3'd1;
                    if (oct == 3'd7) begin
                        ox <= nx;
                        oy <= ny;
                        d  <= nd;
                        if (ny > nx) begin
                            state <= E_IDLE;
                        end
                    end
                end
                default: state <= E_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/circle_scene.sv
// Scene sequencer: optionally clears the screen to black, then draws
// NUM_CIRCLES concentric circles through one circle_engine and holds done
// until start drops. Build option: define CIRCLE_SCENE_CLEAR_EN to include
// the clear phase; without it a scene goes straight from IDLE to DRAW.
module circle_scene
    import circle_scene_pkg::*;
#(
    parameter int SCR_W       = 160,
    parameter int SCR_H       = 120,
    parameter int NUM_CIRCLES = 4,
    parameter int R_STEP      = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          centre_x,
    input  logic [6:0]          centre_y,
    input  logic [7:0]          base_radius,
    output logic                done,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam logic [7:0] X_LAST = 8'(SCR_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCR_H - 1);
    localparam logic [2:0] K_LAST = 3'(NUM_CIRCLES - 1);

    scene_state_t state;
    logic [2:0]   k;
    logic [7:0]   lat_x;
    logic [6:0]   lat_y;
    logic [7:0]   lat_r;
    logic [7:0]   clr_x;
    logic [6:0]   clr_y;

    logic                eng_start;
    logic                eng_done;
    logic                eng_valid;
    logic [7:0]          eng_x;
    logic [6:0]          eng_y;
    logic [COLOUR_W-1:0] eng_colour;
    logic [7:0]          eng_radius;
    logic [COLOUR_W-1:0] eng_draw_colour;

    assign eng_start       = (state == S_DRAW);
    assign eng_radius      = circle_radius(lat_r, k, R_STEP);
    assign eng_draw_colour = circle_colour(k);

    circle_engine #(
        .SCR_W (SCR_W),
        .SCR_H (SCR_H)
    ) u_engine (
        .clk        (clk),
        .rst        (rst),
        .start      (eng_start),
        .centre_x   (lat_x),
        .centre_y   (lat_y),
        .radius     (eng_radius),
        .colour     (eng_draw_colour),
        .done       (eng_done),
        .pix_valid  (eng_valid),
        .pix_x      (eng_x),
        .pix_y      (eng_y),
        .pix_colour (eng_colour)
    );

    // Scene sequencer: clear raster, one engine run per circle, then hold done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            k     <= '0;
            done  <= 1'b0;
            lat_x <= '0;
            lat_y <= '0;
            lat_r <= '0;
            clr_x <= '0;
            clr_y <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lat_x <= centre_x;
                        lat_y <= centre_y;
                        lat_r <= base_radius;
                        k     <= '0;
                        clr_x <= '0;
                        clr_y <= '0;
`ifdef CIRCLE_SCENE_CLEAR_EN
                        state <= S_CLEAR;
`else
                        state <= S_DRAW;
`endif
                    end
                end
                S_CLEAR: begin
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        if (clr_y == Y_LAST) begin
                            state <= S_DRAW;
                        end else begin
                            clr_y <= clr_y + 7'd1;
                        end
                    end else begin
                        clr_x <= clr_x + 8'd1;
                    end
                end
                S_DRAW: state <= S_WAIT;
                S_WAIT: begin
                    if (eng_done) begin
                        k <= k + 3'd1;
                        if (k == K_LAST) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= S_DRAW;
                        end
                    end
                end
                S_FINISH: begin
                    if (!start) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pixel port: clear raster or clipped engine pixels, silent in every other state
    always_comb begin
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = COLOUR_BLACK;
        if (state == S_CLEAR) begin
            vga_plot = 1'b1;
            vga_x    = clr_x;
            vga_y    = clr_y;
        end else if ((state == S_WAIT) && eng_valid) begin
            vga_plot   = 1'b1;
            vga_x      = eng_x;
            vga_y      = eng_y;
            vga_colour = eng_colour;
        end
    end

endmodule

// File: tb/tb_circle_scene.sv
// Self-checking bench for circle_scene: table of scenes with hand-derived
// first pixels, a behavioural pixel-stream model, reset and start-drop cases,
// and randomized scenes. Honours CIRCLE_SCENE_CLEAR_EN like the RTL.
module tb_circle_scene;

    localparam int SCR_W       = 160;
    localparam int SCR_H       = 120;
    localparam int NUM_CIRCLES = 4;
    localparam int R_STEP      = 10;
`ifdef CIRCLE_SCENE_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif
    localparam int SCENE_LIMIT = 40000;
    localparam int N_TAB       = CLEAR_EN ? 3 : 5;
    localparam int N_RAND      = CLEAR_EN ? 0 : 6;
    localparam int RST_AT      = CLEAR_EN ? 5001 : 20;

    typedef logic [17:0] pix_t;   // {x[7:0], y[6:0], colour[2:0]}

    typedef struct {
        int cx;
        int cy;
        int br;
        bit drop;
        int f0x;
        int f0y;
        int fnx;
        int fny;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] base_radius;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int n_checks;
    int n_pass;

    pix_t cap_q[$];
    pix_t exp_q[$];

    circle_scene #(
        .SCR_W       (SCR_W),
        .SCR_H       (SCR_H),
        .NUM_CIRCLES (NUM_CIRCLES),
        .R_STEP      (R_STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .base_radius (base_radius),
        .done        (done),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic pix_t mk_pix(input int x, input int y, input int c);
        return {x[7:0], y[6:0], c[2:0]};
    endfunction

    // Reference: the whole scene as an ordered list of plotted pixels.
    task automatic build_expected(input int cx, input int cy, input int br);
        exp_q.delete();
        if (CLEAR_EN) begin
            for (int y = 0; y < SCR_H; y++)
                for (int x = 0; x < SCR_W; x++)
                    exp_q.push_back(mk_pix(x, y, 0));
        end
        for (int k = 0; k < NUM_CIRCLES; k++) begin
            int r, c, x, y, d;
            r = br + k * R_STEP;
            if (r > 255) r = 255;
            c = (k % 7) + 1;
            x = r;
            y = 0;
            d = 1 - r;
            while (y <= x) begin
                int px[8];
                int py[8];
                px = '{cx + x, cx + y, cx - y, cx - x, cx - x, cx - y, cx + y, cx + x};
                py = '{cy + y, cy + x, cy + x, cy + y, cy - y, cy - x, cy - x, cy - y};
                for (int i = 0; i < 8; i++)
                    if (px[i] >= 0 && px[i] < SCR_W && py[i] >= 0 && py[i] < SCR_H)
                        exp_q.push_back(mk_pix(px[i], py[i], c));
                y++;
                if (d < 0) begin
                    d += 2 * y + 1;
                end else begin
                    x--;
                    d += 2 * (y - x) + 1;
                end
            end
        end
    endtask

    function automatic int find_first(input int colour);
        for (int i = 0; i < cap_q.size(); i++)
            if (int'(cap_q[i][2:0]) == colour) return int'(cap_q[i]);
        return -1;
    endfunction

    task automatic compare_stream(input string tag);
        int diff;
        diff = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            if (cap_q[i] != exp_q[i]) begin
                diff = i;
                break;
            end
        end
        check({tag, "_stream_len"}, cap_q.size(), exp_q.size());
        check({tag, "_stream_first_diff"}, diff, -1);
        if (diff >= 0) check({tag, "_stream_pixel"}, int'(cap_q[diff]), int'(exp_q[diff]));
    endtask

    // Run one scene; optionally drop start once circle 1 starts plotting.
    task automatic run_scene(input int cx, input int cy, input int br, input bit drop,
                             input string tag, output int lat);
        int cyc;
        int offs;
        build_expected(cx, cy, br);
        cap_q.delete();
        lat  = -1;
        offs = 0;
        cyc  = 0;
        @(negedge clk);
        centre_x    = 8'(cx);
        centre_y    = 7'(cy);
        base_radius = 8'(br);
        start       = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (vga_plot) begin
                if (lat < 0) lat = cyc;
                if (vga_x >= SCR_W || vga_y >= SCR_H) offs++;
                cap_q.push_back({vga_x, vga_y, vga_colour});
                if (drop && vga_colour == 3'd2) start = 1'b0;
            end
            if (cyc == 7) begin
                centre_x    = 8'($urandom);
                centre_y    = 7'($urandom);
                base_radius = 8'($urandom);
            end
        end while (!done && cyc < SCENE_LIMIT);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_offscreen_plots"}, offs, 0);
        compare_stream(tag);
        if (!start) begin
            @(negedge clk);
            check({tag, "_done_one_cycle"}, int'(done), 0);
        end else begin
            @(negedge clk);
            check({tag, "_done_held"}, int'(done), 1);
            check({tag, "_plot_in_finish"}, int'(vga_plot), 0);
            start = 1'b0;
            @(negedge clk);
            check({tag, "_done_cleared"}, int'(done), 0);
        end
    endtask

    // Reset in the middle of a scene, then restart from scratch.
    task automatic reset_mid_scene();
        int cyc, cnt, quiet;
        build_expected(80, 60, 30);
        @(negedge clk);
        centre_x    = 8'd80;
        centre_y    = 7'd60;
        base_radius = 8'd30;
        start       = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < RST_AT && cyc < SCENE_LIMIT) begin
            @(negedge clk);
            cyc++;
            if (vga_plot) cnt++;
        end
        check("rst_point_reached", cnt, RST_AT);
        check("rst_plot_before", int'(vga_plot), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_plot", int'(vga_plot), 0);
        check("rst_async_xy", int'({vga_x, vga_y}), 0);
        check("rst_async_colour", int'(vga_colour), 0);
        check("rst_async_done", int'(done), 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        quiet = 0;
        repeat (8) begin
            @(negedge clk);
            if (vga_plot) quiet++;
        end
        check("rst_no_plot_without_start", quiet, 0);
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!vga_plot && cyc < 10);
        check("rst_restart_plot_seen", int'(vga_plot), 1);
        check("rst_restart_first_pixel", int'({vga_x, vga_y, vga_colour}), int'(exp_q[0]));
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    initial begin
        vec_t tab[5];
        int   lat;
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        centre_x    = '0;
        centre_y    = '0;
        base_radius = '0;

        // {cx, cy, br, drop, circle0 first (x,y), last circle first (x,y)}
        tab[0] = '{80,  60, 10,  1'b0, 90, 60,  120, 60};
        tab[1] = '{0,   0,  20,  1'b1, 20, 0,   50,  0};
        tab[2] = '{255, 0,  250, 1'b0, 5,  0,   0,   0};
        tab[3] = '{80,  60, 0,   1'b0, 80, 60,  110, 60};
        tab[4] = '{40,  100, 5,  1'b0, 45, 100, 75,  100};

        #1;
        check("reset_plot", int'(vga_plot), 0);
        check("reset_done", int'(done), 0);
        check("reset_xy_colour", int'({vga_x, vga_y, vga_colour}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_plot", int'(vga_plot), 0);

        for (int i = 0; i < N_TAB; i++) begin
            run_scene(tab[i].cx, tab[i].cy, tab[i].br, tab[i].drop, $sformatf("tab%0d", i), lat);
            if (i == 0) check("first_plot_latency", lat, CLEAR_EN ? 1 : 2);
            check($sformatf("tab%0d_first_c0", i), find_first(1), int'(mk_pix(tab[i].f0x, tab[i].f0y, 1)));
            check($sformatf("tab%0d_first_last", i), find_first(NUM_CIRCLES),
                  int'(mk_pix(tab[i].fnx, tab[i].fny, NUM_CIRCLES)));
        end

        reset_mid_scene();

        for (int i = 0; i < N_RAND; i++) begin
            run_scene(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      $sformatf("rnd%0d", i), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
